// File: rtl/program_loader_pkg.sv
// Shared constants and helpers for the boot-time program loader.
// Holds the FSM encodings and the default memory depth.
package program_loader_pkg;

   localparam int LOADER_DEPTH = 1024;
   localparam int LOADER_CW    = 11;

   localparam logic [1:0] LOADER_IDLE  = 2'd0;
   localparam logic [1:0] LOADER_LOAD  = 2'd1;
   localparam logic [1:0] LOADER_WRITE = 2'd2;
   localparam logic [1:0] LOADER_DONE  = 2'd3;

   // Big-endian assembly: earlier bytes move toward the MSB.
   function automatic logic [31:0] lane_shift(
      input logic [31:0] w,
      input logic [7:0]  b
   );
      return {w[23:0], b};
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream handshake between the host byte source and the loader.
// The host is the master; the loader is the slave.
interface program_loader_if;

   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;

   modport master (
      output byte_in,
      output byte_valid,
      input  byte_ready
   );

   modport slave (
      input  byte_in,
      input  byte_valid,
      output byte_ready
   );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects four bytes into one big-endian 32-bit word.
// Lane counter wraps to 0 after the fourth byte.
module program_loader_word_assembler (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift_enable,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_complete
);

   import program_loader_pkg::*;

   logic [1:0]  lane_q;
   logic [1:0]  lane_d;
   logic [31:0] word_q;
   logic [31:0] word_d;

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (clear) begin
         lane_d = 2'd0;
      end else if (shift_enable) begin
         lane_d = lane_q + 2'd1;
         word_d = lane_shift(word_q, byte_in);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lane_q <= 2'd0;
         word_q <= 32'd0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

   assign word          = word_q;
   assign word_complete = shift_enable && (lane_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams bytes into instruction memory words and
// holds the CPU in reset until the whole program is written.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int DEPTH = LOADER_DEPTH,
   parameter int CW    = LOADER_CW
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] word_count,
   program_loader_if.slave bus,
   output logic          mem_write_enable,
   output logic [31:0]   mem_address,
   output logic [31:0]   mem_write_data,
   output logic          cpu_reset_n,
   output logic          busy,
   output logic          done,
   output logic          error
);

   logic [1:0]    state_q;
   logic [1:0]    state_d;
   logic [CW-1:0] k_q;
   logic [CW-1:0] k_d;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [CW-1:0] k_next;
   logic [31:0]   addr_q;
   logic [31:0]   addr_d;
   logic          error_q;
   logic          error_d;
   logic          ready_q;
   logic          ready_d;
   logic          we_q;
   logic          we_d;
   logic          busy_q;
   logic          busy_d;
   logic          done_q;
   logic          done_d;
   logic          run_q;
   logic          run_d;
   logic          clear;
   logic          shift;
   logic [31:0]   word;
   logic          word_complete;

   // Kept outside the FSM block so the assembler's
   // completion flag never loops back into it.
   assign shift  = (state_q == LOADER_LOAD)
                 && bus.byte_valid && !abort;
   assign k_next = k_q + CW'(1);

   program_loader_word_assembler u_word_assembler (
      .clock         (clock),
      .reset         (reset),
      .clear         (clear),
      .shift_enable  (shift),
      .byte_in       (bus.byte_in),
      .word          (word),
      .word_complete (word_complete)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      count_d = count_q;
      addr_d  = addr_q;
      error_d = error_q;
      clear   = 1'b0;
      unique case (state_q)
         LOADER_IDLE, LOADER_DONE: begin
            if (start) begin
               if (word_count > CW'(DEPTH)) begin
                  error_d = 1'b1;
                  state_d = LOADER_IDLE;
               end else if (word_count == '0) begin
                  error_d = 1'b0;
                  state_d = LOADER_DONE;
               end else begin
                  count_d = word_count;
                  k_d     = '0;
                  clear   = 1'b1;
                  error_d = 1'b0;
                  state_d = LOADER_LOAD;
               end
            end
         end
         LOADER_LOAD: begin
            if (abort) begin
               error_d = 1'b1;
               clear   = 1'b1;
               state_d = LOADER_IDLE;
            end else if (word_complete) begin
               addr_d  = 32'({k_q, 2'b00});
               state_d = LOADER_WRITE;
            end
         end
         LOADER_WRITE: begin
            clear = 1'b1;
            if (abort) begin
               error_d = 1'b1;
               state_d = LOADER_IDLE;
            end else begin
               k_d     = k_next;
               state_d = (k_next == count_q)
                       ? LOADER_DONE : LOADER_LOAD;
            end
         end
         default: begin
            state_d = LOADER_IDLE;
         end
      endcase
   end

   // Outputs are registered copies of the next-state decode.
   always_comb begin
      ready_d = (state_d == LOADER_LOAD);
      we_d    = (state_d == LOADER_WRITE);
      busy_d  = (state_d == LOADER_LOAD)
             || (state_d == LOADER_WRITE);
      done_d  = (state_d == LOADER_DONE);
      run_d   = (state_d == LOADER_DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= LOADER_IDLE;
         k_q     <= '0;
         count_q <= '0;
         addr_q  <= 32'd0;
         error_q <= 1'b0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         error_q <= error_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         run_q   <= run_d;
      end
   end

   assign bus.byte_ready   = ready_q;
   assign mem_write_enable = we_q;
   assign mem_address      = addr_q;
   assign mem_write_data   = word;
   assign cpu_reset_n      = run_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign error            = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random byte streams
// compared against a word-list model of the expected writes.
module tb_program_loader;

   localparam int DEPTH = 1024;
   localparam int CW    = 11;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [CW-1:0] word_count = '0;
   logic          mem_write_enable;
   logic [31:0]   mem_address;
   logic [31:0]   mem_write_data;
   logic          cpu_reset_n;
   logic          busy;
   logic          done;
   logic          error;

   program_loader_if bus();

   program_loader #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .abort            (abort),
      .word_count       (word_count),
      .bus              (bus),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .cpu_reset_n      (cpu_reset_n),
      .busy             (busy),
      .done             (done),
      .error            (error)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  stream[$];
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   int          got_acc[$];
   int          acc = 0;
   int          wbase;
   int          abase;

   // Memory samples writes on the negedge; also count bytes
   // that will be taken at the following posedge.
   always @(negedge clock) begin
      if (mem_write_enable) begin
         got_addr.push_back(mem_address);
         got_data.push_back(mem_write_data);
         got_acc.push_back(acc);
      end
      if (bus.byte_valid && bus.byte_ready) acc++;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic mark();
      wbase = got_addr.size();
      abase = acc;
   endtask

   task automatic fill(input int n);
      stream.delete();
      for (int i = 0; i < 4 * n; i++)
         stream.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic do_start(input int n);
      start      = 1'b1;
      word_count = CW'(n);
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   // mode 0: continuous, 1: valid every other cycle, 2: random
   task automatic drive(input int first, input int last,
                        input int mode);
      int   idx;
      int   cyc;
      logic will;
      idx = first;
      cyc = 0;
      while (idx < last && cyc < 8 * (last - first) + 20) begin
         case (mode)
            0:       bus.byte_valid = 1'b1;
            1:       bus.byte_valid = (cyc % 2 == 1);
            default: bus.byte_valid = 1'($urandom_range(0, 1));
         endcase
         bus.byte_in = stream[idx];
         @(negedge clock);
         will = bus.byte_valid && bus.byte_ready;
         @(posedge clock); #1;
         if (will) idx++;
         cyc++;
      end
      bus.byte_valid = 1'b0;
      check("drive_done", idx, last);
   endtask

   task automatic compare_writes(input int n);
      logic [31:0] exp_word;
      check("wr_count", got_addr.size() - wbase, n);
      for (int i = 0; i < n && wbase + i < got_addr.size(); i++) begin
         exp_word = {stream[4*i], stream[4*i+1],
                     stream[4*i+2], stream[4*i+3]};
         check("wr_addr", got_addr[wbase+i], 4 * i);
         check("wr_data", got_data[wbase+i], exp_word);
         check("wr_whole", got_acc[wbase+i] - abase, 4 * (i + 1));
      end
   endtask

   task automatic finish_load();
      check("last_we", mem_write_enable, 1);
      check("cpu_held", cpu_reset_n, 0);
      @(posedge clock); #1;
      check("done", done, 1);
      check("cpu_run", cpu_reset_n, 1);
      check("we_off", mem_write_enable, 0);
      check("busy_off", busy, 0);
      check("err_clear", error, 0);
   endtask

   task automatic load(input int n, input int mode);
      mark();
      do_start(n);
      check("ready_after_start", bus.byte_ready, 1);
      check("busy_after_start", busy, 1);
      drive(0, 4 * n, mode);
      finish_load();
      compare_writes(n);
   endtask

   task automatic idle_wait();
      repeat (6) @(posedge clock);
      #1;
   endtask

   initial begin
      int n;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'd0;
      #2;
      check("rst_we", mem_write_enable, 0);
      check("rst_addr", mem_address, 0);
      check("rst_data", mem_write_data, 0);
      check("rst_cpu", cpu_reset_n, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", error, 0);
      check("rst_ready", bus.byte_ready, 0);
      #10 reset = 1'b1;
      @(posedge clock); #1;

      stream = '{8'h8C, 8'h01, 8'h00, 8'h04,
                 8'hAC, 8'h02, 8'h00, 8'h08};
      load(2, 0);
      check("w0_const", got_data[wbase], 32'h8C010004);
      check("w1_const", got_data[wbase+1], 32'hAC020008);
      load(2, 1);

      repeat (4) begin
         n = $urandom_range(1, 6);
         fill(n);
         load(n, 2);
      end

      do_start(1025);
      check("big_err", error, 1);
      check("big_busy", busy, 0);
      check("big_done", done, 0);
      check("big_cpu", cpu_reset_n, 0);
      check("big_ready", bus.byte_ready, 0);

      mark();
      do_start(0);
      check("zero_done", done, 1);
      check("zero_err", error, 0);
      check("zero_cpu", cpu_reset_n, 1);
      check("zero_busy", busy, 0);
      idle_wait();
      check("zero_writes", got_addr.size() - wbase, 0);

      fill(3);
      mark();
      do_start(3);
      drive(0, 5, 0);
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      check("abl_err", error, 1);
      check("abl_busy", busy, 0);
      check("abl_ready", bus.byte_ready, 0);
      check("abl_cpu", cpu_reset_n, 0);
      idle_wait();
      compare_writes(1);
      fill(1);
      load(1, 0);

      fill(2);
      mark();
      do_start(2);
      drive(0, 4, 0);
      check("abw_we", mem_write_enable, 1);
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      check("abw_err", error, 1);
      check("abw_we_off", mem_write_enable, 0);
      check("abw_cpu", cpu_reset_n, 0);
      idle_wait();
      compare_writes(1);

      fill(2);
      mark();
      do_start(2);
      drive(0, 4, 0);
      #2 reset = 1'b0;
      #1;
      check("arst_we", mem_write_enable, 0);
      check("arst_addr", mem_address, 0);
      check("arst_busy", busy, 0);
      check("arst_ready", bus.byte_ready, 0);
      check("arst_cpu", cpu_reset_n, 0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      check("arst_writes", got_addr.size() - wbase, 0);
      fill(1);
      load(1, 0);

      fill(DEPTH);
      load(DEPTH, 0);
      check("depth_last", got_addr[got_addr.size()-1], 32'd4092);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
